fetch_sequencer: RTL
====================

# fetch_sequencer

Holds the architectural program counter, fetches one instruction at a time from instruction memory over a request/ready handshake, and presents it to decode/execute. It consumes the jump-unit result that closes each instruction, the taken flag plus the next-PC target produced by the JAL/JALR and branch units, and redirects the next fetch accordingly. It is strictly non-pipelined: one instruction in flight, fetch and execute alternate.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC of the first fetch after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned jump target (macro builds only)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- mem_request  output  1  instruction-memory read request
- mem_address  output  32  word address of the requested instruction
- mem_ready  input  1  memory has mem_read_data valid this cycle
- mem_read_data  input  32  instruction word
- instruction_valid  output  1  instruction/program_counter valid for execute
- instruction  output  32  latched instruction word
- program_counter  output  32  PC of the latched instruction
- execute_done  input  1  one-cycle pulse: execute finished current instruction
- execute_take_jump  input  1  with execute_done: redirect to execute_jump_target
- execute_jump_target  input  32  next PC from jump/branch units
- misaligned_fault  output  1  one-cycle pulse on misaligned target
- fault_address  output  32  offending target, held until next fault

## Operation
- All outputs registered. Reset values: mem_request 0, mem_address RESET_VECTOR, instruction_valid 0, instruction 0, program_counter RESET_VECTOR, misaligned_fault 0, fault_address 0; state START.
- START: first edge with reset_n high -> REQUEST, mem_request 1, mem_address = program_counter.
- REQUEST: mem_request and mem_address held stable until mem_ready sampled high. On that edge: instruction <= mem_read_data, instruction_valid <= 1, mem_request <= 0 -> EXECUTE.
- EXECUTE: instruction and program_counter held stable. On execute_done edge: instruction_valid <= 0; next = execute_take_jump ? execute_jump_target : program_counter + 4 (32-bit, wraps 32'hFFFF_FFFC -> 0); program_counter <= next, mem_address <= next, mem_request <= 1 -> REQUEST.
- execute_done in START/REQUEST ignored; mem_ready outside REQUEST ignored; execute_take_jump and execute_jump_target ignored unless execute_done high.
- Fall-through PC (+4) never faults.
- Async reset at any point (including mid-handshake) returns immediately to reset values; any outstanding memory response is dropped.

## Timing
- mem_ready high at edge N -> instruction_valid high after edge N (visible cycle N+1).
- execute_done high at edge M -> instruction_valid low and mem_request high with new mem_address after edge M.
- Zero-wait memory (mem_ready tied high): 2 cycles per instruction plus execute latency.
- misaligned_fault high for exactly the cycle after the faulting execute_done edge.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: taken target with bits[1:0] != 0 -> program_counter/mem_address <= TRAP_VECTOR, fault_address <= target, misaligned_fault pulses; fetch continues from TRAP_VECTOR.
- Undefined: target loaded verbatim regardless of alignment; misaligned_fault and fault_address constant 0; TRAP_VECTOR unused.

## Test plan
- Reset release, mem_ready tied 1, memory returns 32'h0000_0013 -> mem_address 0 fetched, instruction_valid next cycle, program_counter 0.
- execute_done with take_jump 0 from PC 32'h0000_0010 -> next mem_address 32'h0000_0014; from 32'hFFFF_FFFC -> 32'h0000_0000.
- execute_done, take_jump 1, target 32'h0000_0200 -> mem_address 32'h0000_0200, program_counter updates, no fault.
- mem_ready delayed 5 cycles -> mem_request and mem_address stable all 5 cycles, instruction latched on 6th; execute_done pulsed during wait ignored.
- Macro defined, take_jump 1, target 32'h0000_0102 -> misaligned_fault one-cycle pulse, fault_address 32'h0000_0102, next fetch 32'h0000_0100; macro undefined -> fetch 32'h0000_0102, no pulse.
- reset_n low while mem_request high -> mem_request 0 immediately; after release fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: non-pipelined instruction fetch sequencer.
// Holds the architectural PC and fetches one instruction at a time over a
// request/ready handshake. The fetched word is held for execute until execute
// signals done. The next fetch then goes to PC+4 or to the jump target.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap taken jump targets
// with bits[1:0] != 0 to TRAP_VECTOR and report them on misaligned_fault and
// fault_address. Without it, targets load verbatim and both fault outputs stay 0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   mem_request/address   instruction-memory read request and word address
//   mem_ready/read_data   memory response handshake and instruction word
//   instruction_valid     instruction/program_counter valid for execute
//   instruction           latched instruction word
//   program_counter       PC of the latched instruction
//   execute_done          one-cycle pulse closing the current instruction
//   execute_take_jump     with execute_done: redirect to execute_jump_target
//   execute_jump_target   next PC from the jump/branch units
//   misaligned_fault      one-cycle pulse on a trapped misaligned target
//   fault_address         last offending target, held until the next fault
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_request,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] program_counter,
  input  logic        execute_done,
  input  logic        execute_take_jump,
  input  logic [31:0] execute_jump_target,
  output logic        misaligned_fault,
  output logic [31:0] fault_address
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100;
`endif

  typedef enum logic [1:0] {
    START   = 2'd0,
    REQUEST = 2'd1,
    EXECUTE = 2'd2
  } state_t;

  state_t state, state_next;

  logic            mem_request_next;
  logic [XLEN-1:0] mem_address_next;
  logic            instruction_valid_next;
  logic [XLEN-1:0] instruction_next;
  logic [XLEN-1:0] program_counter_next;
  logic            misaligned_fault_next;
  logic [XLEN-1:0] fault_address_next;
  logic [XLEN-1:0] redirect_pc;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= START;
      mem_request       <= 1'b0;
      mem_address       <= RESET_VECTOR;
      instruction_valid <= 1'b0;
      instruction       <= '0;
      program_counter   <= RESET_VECTOR;
      misaligned_fault  <= 1'b0;
      fault_address     <= '0;
    end else begin
      state             <= state_next;
      mem_request       <= mem_request_next;
      mem_address       <= mem_address_next;
      instruction_valid <= instruction_valid_next;
      instruction       <= instruction_next;
      program_counter   <= program_counter_next;
      misaligned_fault  <= misaligned_fault_next;
      fault_address     <= fault_address_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      START:   state_next = REQUEST;
      REQUEST: if (mem_ready) state_next = EXECUTE;
      EXECUTE: if (execute_done) state_next = REQUEST;
      default: state_next = START;
    endcase
  end

  // Sequential PC: jump target when taken, else PC+4 (wraps at 2^32)
  always_comb begin
    redirect_pc = execute_take_jump ? execute_jump_target
                                    : program_counter + XLEN'(4);
  end

  // Next values for the registered outputs
  always_comb begin
    mem_request_next       = mem_request;
    mem_address_next       = mem_address;
    instruction_valid_next = instruction_valid;
    instruction_next       = instruction;
    program_counter_next   = program_counter;
    misaligned_fault_next  = 1'b0;
    fault_address_next     = fault_address;
    unique case (state)
      START: begin
        mem_request_next = 1'b1;
        mem_address_next = program_counter;
      end
      REQUEST: begin
        if (mem_ready) begin
          instruction_next       = mem_read_data;
          instruction_valid_next = 1'b1;
          mem_request_next       = 1'b0;
        end
      end
      EXECUTE: begin
        if (execute_done) begin
          instruction_valid_next = 1'b0;
          mem_request_next       = 1'b1;
          program_counter_next   = redirect_pc;
          mem_address_next       = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
          // Only taken targets can be misaligned; PC+4 keeps alignment.
          if (execute_take_jump && (execute_jump_target[1:0] != 2'b00)) begin
            program_counter_next  = TRAP_VECTOR;
            mem_address_next      = TRAP_VECTOR;
            fault_address_next    = execute_jump_target;
            misaligned_fault_next = 1'b1;
          end
`endif
        end
      end
      default: begin
        mem_request_next       = 1'b0;
        instruction_valid_next = 1'b0;
      end
    endcase
  end

endmodule
